// File: rtl/branch_predictor_pkg.sv
// Shared sizes, bit ranges and counter encodings for the
// fetch-stage branch predictor (BTB + gshare PHT + BHR).
package branch_predictor_pkg;

  localparam int BTB_ENTRIES = 32;
  localparam int PHT_ENTRIES = 32;
  localparam int IDX_W       = 5;
  localparam int BHR_W       = 5;
  localparam int IDX_LO      = 2;
  localparam int IDX_HI      = 6;
  localparam int TAG_LO      = 7;
  localparam int TAG_W       = 32 - TAG_LO;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } cnt_e;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic             is_cond;
  } btb_entry_t;

  function automatic logic [1:0] cnt_next(
    input logic [1:0] c,
    input logic       taken
  );
    logic [1:0] n;
    n = c;
    unique case (1'b1)
      taken && (c != CNT_ST):   n = c + 2'd1;
      !taken && (c != CNT_SNT): n = c - 2'd1;
      default: ;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/branch_predictor_btb.sv
// Branch target buffer: direct-mapped, combinational read,
// one synchronous write; only valid bits are reset.
module btb
  import branch_predictor_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             rd_hit,
  output logic [31:0]      rd_target,
  output logic             rd_is_cond,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  btb_entry_t       wr_entry
);

  logic [BTB_ENTRIES-1:0] valid_q, valid_d;
  btb_entry_t entry_q [BTB_ENTRIES];
  btb_entry_t entry_d [BTB_ENTRIES];

  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
      entry_d[wr_idx] = wr_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    entry_q <= entry_d;
  end

  always_comb begin
    rd_hit     = valid_q[rd_idx]
               && (entry_q[rd_idx].tag == rd_tag);
    rd_target  = entry_q[rd_idx].target;
    rd_is_cond = entry_q[rd_idx].is_cond;
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage predictor: BTB for targets, gshare PHT
// indexed by pc[6:2] ^ BHR for conditional direction.
module branch_predictor
  import branch_predictor_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       pc,
  output logic              pred_taken,
  output logic [31:0]       pred_next_pc,
  output logic [IDX_W-1:0]  pred_idx,
  input  logic              update_en,
  input  logic [31:0]       update_pc,
  input  logic [IDX_W-1:0]  update_idx,
  input  logic              update_is_branch,
  input  logic              update_taken,
  input  logic [31:0]       update_target
);

  logic [1:0]       pht_q [PHT_ENTRIES];
  logic [1:0]       pht_d [PHT_ENTRIES];
  logic [BHR_W-1:0] bhr_q, bhr_d;

  logic             hit;
  logic [31:0]      btb_target;
  logic             btb_is_cond;
  logic             btb_we;
  btb_entry_t       btb_wdata;
  logic             unused_lo;

  assign unused_lo = ^{pc[1:0], update_pc[1:0]};

  assign btb_we = update_en && update_taken && !reset;

  always_comb begin
    btb_wdata.tag     = update_pc[31:TAG_LO];
    btb_wdata.target  = update_target;
    btb_wdata.is_cond = update_is_branch;
  end

  btb u_btb (
    .clk        (clk),
    .reset      (reset),
    .rd_idx     (pc[IDX_HI:IDX_LO]),
    .rd_tag     (pc[31:TAG_LO]),
    .rd_hit     (hit),
    .rd_target  (btb_target),
    .rd_is_cond (btb_is_cond),
    .wr_en      (btb_we),
    .wr_idx     (update_pc[IDX_HI:IDX_LO]),
    .wr_entry   (btb_wdata)
  );

  always_comb begin
    pred_idx     = pc[IDX_HI:IDX_LO] ^ bhr_q;
    pred_taken   = hit
                 && (!btb_is_cond || pht_q[pred_idx][1]);
    pred_next_pc = pred_taken ? btb_target : pc + 32'd4;
  end

  // Jumps train the BTB only; history tracks branches
  always_comb begin
    pht_d = pht_q;
    bhr_d = bhr_q;
    if (update_en && update_is_branch) begin
      pht_d[update_idx] =
        cnt_next(pht_q[update_idx], update_taken);
      bhr_d = {bhr_q[BHR_W-2:0], update_taken};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PHT_ENTRIES; i++)
        pht_q[i] <= CNT_WNT;
      bhr_q <= '0;
    end else begin
      pht_q <= pht_d;
      bhr_q <= bhr_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: expected lookups
// are queued when driven and popped when the DUT settles.
module tb_branch_predictor;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_next_pc;
  logic [4:0]  pred_idx;
  logic        update_en;
  logic [31:0] update_pc;
  logic [4:0]  update_idx;
  logic        update_is_branch;
  logic        update_taken;
  logic [31:0] update_target;

  int n_run;
  int n_fail;
  logic [4:0] bhr;

  typedef struct {
    string       tag;
    logic        tk;
    logic [31:0] npc;
    logic [4:0]  idx;
  } exp_t;

  exp_t sb [$];

  branch_predictor dut (
    .clk              (clk),
    .reset            (reset),
    .pc               (pc),
    .pred_taken       (pred_taken),
    .pred_next_pc     (pred_next_pc),
    .pred_idx         (pred_idx),
    .update_en        (update_en),
    .update_pc        (update_pc),
    .update_idx       (update_idx),
    .update_is_branch (update_is_branch),
    .update_taken     (update_taken),
    .update_target    (update_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push_exp(
    input string       t,
    input logic        tk,
    input logic [31:0] npc,
    input logic [4:0]  idx
  );
    exp_t e;
    e.tag = t;
    e.tk  = tk;
    e.npc = npc;
    e.idx = idx;
    sb.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".taken"}, {31'd0, pred_taken}, {31'd0, e.tk});
      chk({e.tag, ".npc"}, pred_next_pc, e.npc);
      chk({e.tag, ".idx"}, {27'd0, pred_idx}, {27'd0, e.idx});
    end
  endtask

  task automatic look(
    input string       t,
    input logic [31:0] p,
    input logic        tk,
    input logic [31:0] npc,
    input logic [4:0]  idx
  );
    push_exp(t, tk, npc, idx);
    pc = p;
    #1;
    pop_cmp();
  endtask

  task automatic upd(
    input logic [31:0] p,
    input logic [4:0]  idx,
    input logic        br,
    input logic        tk,
    input logic [31:0] tgt
  );
    @(negedge clk);
    update_en        = 1'b1;
    update_pc        = p;
    update_idx       = idx;
    update_is_branch = br;
    update_taken     = tk;
    update_target    = tgt;
    @(posedge clk);
    #1;
    update_en = 1'b0;
    if (br) bhr = {bhr[3:0], tk};
  endtask

  // Lookup hitting the filled BTB slot whose gshare index is 5
  task automatic look_sat(input string t, input logic tk);
    logic [4:0]  k;
    logic [31:0] p;
    k = 5'h05 ^ bhr;
    p = 32'h1000 + {25'd0, k, 2'b00};
    look(t, p, tk,
         tk ? 32'h8000 + {25'd0, k, 2'b00} : p + 32'd4,
         5'h05);
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    bhr = 5'd0;
    pc = 32'h0;
    reset = 1'b1;
    update_en = 1'b1;
    update_pc = 32'h100;
    update_idx = 5'h00;
    update_is_branch = 1'b1;
    update_taken = 1'b1;
    update_target = 32'h80;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    update_en = 1'b0;

    look("rst_100", 32'h100, 1'b0, 32'h104, 5'h00);
    look("rst_any", 32'h12345678, 1'b0, 32'h1234567C, 5'h1E);

    upd(32'h100, 5'h00, 1'b1, 1'b1, 32'h80);
    look("br1", 32'h100, 1'b0, 32'h104, 5'h01);
    upd(32'h100, 5'h01, 1'b1, 1'b1, 32'h80);
    look("br2", 32'h100, 1'b0, 32'h104, 5'h03);

    upd(32'h200, 5'h1F, 1'b0, 1'b1, 32'h400);
    look("jal_hit", 32'h200, 1'b1, 32'h400, 5'h03);
    look("jal_evict", 32'h100, 1'b0, 32'h104, 5'h03);
    look("jal_zero", 32'h000, 1'b0, 32'h004, 5'h03);

    for (int i = 0; i < 32; i++)
      upd(32'h1000 + i * 4, 5'h1F, 1'b1, 1'b1,
          32'h8000 + i * 4);
    look("fill_bhr", 32'h1000, 1'b1, 32'h8000, 5'h1F);

    for (int i = 0; i < 5; i++)
      upd(32'h1014, 5'h05, 1'b1, 1'b1, 32'h8014);
    look_sat("sat_st", 1'b1);
    upd(32'h1014, 5'h05, 1'b1, 1'b0, 32'h8014);
    look_sat("sat_wt", 1'b1);
    for (int i = 0; i < 4; i++)
      upd(32'h1014, 5'h05, 1'b1, 1'b0, 32'h8014);
    look_sat("sat_snt", 1'b0);
    upd(32'h1014, 5'h05, 1'b1, 1'b1, 32'h8014);
    look_sat("sat_hold", 1'b0);

    upd(32'h3050, 5'h05, 1'b0, 1'b1, 32'h5000);
    look_sat("jal_no_pht", 1'b0);
    look("jal2_hit", 32'h3050, 1'b1, 32'h5000, 5'h15);
    upd(32'h1014, 5'h05, 1'b1, 1'b1, 32'h8014);
    look_sat("sat_up", 1'b1);

    @(negedge clk);
    update_en = 1'b1;
    update_pc = 32'h300;
    update_idx = 5'h00;
    update_is_branch = 1'b0;
    update_taken = 1'b1;
    update_target = 32'h700;
    push_exp("coll_same", 1'b0, 32'h304, 5'h03);
    pc = 32'h300;
    #1;
    pop_cmp();
    @(posedge clk);
    #1;
    update_en = 1'b0;
    look("coll_next", 32'h300, 1'b1, 32'h700, 5'h03);

    upd(32'h100, 5'h00, 1'b0, 1'b1, 32'h80);
    look("alias_own", 32'h100, 1'b1, 32'h80, 5'h03);
    look("alias_tag", 32'h1100, 1'b0, 32'h1104, 5'h03);
    look("wrap", 32'hFFFFFFFC, 1'b0, 32'h0, 5'h1C);

    upd(32'h2404, 5'h1E, 1'b1, 1'b0, 32'h9000);
    look("no_alloc", 32'h2404, 1'b0, 32'h2408, 5'h07);

    @(negedge clk);
    update_en = 1'b0;
    update_pc = 32'h100;
    update_idx = 5'h06;
    update_is_branch = 1'b1;
    update_taken = 1'b1;
    update_target = 32'h999;
    @(posedge clk);
    #1;
    look("en0", 32'h100, 1'b1, 32'h80, 5'h06);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
